// File: rtl/serial_div_pkg.sv
// Shared definitions for the serial divisibility tracker.
// Holds the FSM state encoding and the default widths used by the top level.
package serial_div_pkg;

    // Frame controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Default divisor/remainder width and frame length width.
    localparam int DIV_W_DEF = 8;
    localparam int LEN_W_DEF = 6;

endpackage : serial_div_pkg

// File: rtl/serial_mod_step.sv
// One MSB-first step of a running modulo: rem_out = ({rem_in, bit_in}) mod divisor.
// Ports:
//   rem_in  - current remainder, always < divisor
//   bit_in  - next bit of the number
//   divisor - non-zero divisor
//   rem_out - updated remainder
module serial_mod_step #(
    parameter int DIV_W = 8
) (
    input  logic [DIV_W-1:0] rem_in,
    input  logic             bit_in,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem_out
);

    logic [DIV_W:0] shifted;

    // rem_in < divisor bounds the shifted value below 2*divisor, so one
    // conditional subtract finishes the reduction. The subtraction is done on
    // the low bits only: the dropped top bit cancels out modulo 2^DIV_W.
    always_comb begin
        shifted = {rem_in, bit_in};
        if (shifted >= {1'b0, divisor}) begin
            rem_out = shifted[DIV_W-1:0] - divisor;
        end else begin
            rem_out = shifted[DIV_W-1:0];
        end
    end

endmodule : serial_mod_step

// File: rtl/serial_divisibility_by_n_fsm.sv
// Serial MSB-first remainder tracker for a runtime divisor with frame control.
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   start        - pulse: latch divisor/num_len, clear remainder, enter RUN
//   divisor      - divisor, sampled on start (0 reports err_div0)
//   num_len      - frame length in bits, sampled on start (0 = unbounded)
//   bit_valid    - new_bit is valid this cycle
//   new_bit      - next bit of the number, MSB first
//   busy         - high while in RUN
//   remainder    - registered prefix mod divisor
//   divisible    - remainder == 0
//   done         - one-cycle pulse after the last bit of a bounded frame
//   err_div0     - one-cycle pulse after start with divisor == 0
module serial_divisibility_by_n_fsm
    import serial_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] divisor,
    input  logic [LEN_W-1:0] num_len,
    input  logic             bit_valid,
    input  logic             new_bit,
    output logic             busy,
    output logic [DIV_W-1:0] remainder,
    output logic             divisible,
    output logic             done,
    output logic             err_div0
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [DIV_W-1:0] step_rem;
    logic [LEN_W:0]   cnt_inc;
    logic [LEN_W-1:0] cnt_sat;

    serial_mod_step #(
        .DIV_W (DIV_W)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (new_bit),
        .divisor (div_q),
        .rem_out (step_rem)
    );

    // The extra carry bit lets the bounded-frame compare see count+1 exactly
    // and lets an unbounded stream saturate the counter instead of wrapping.
    always_comb begin
        cnt_inc = {1'b0, cnt_q} + 1'b1;
        cnt_sat = cnt_inc[LEN_W] ? cnt_q : cnt_inc[LEN_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // start overrides everything, including a bit arriving the same cycle.
        if (start) begin
            rem_d = '0;
            if (divisor != '0) begin
                state_d = RUN;
                cnt_d   = '0;
                div_d   = divisor;
                len_d   = num_len;
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: ;
                RUN: begin
                    if (bit_valid) begin
                        rem_d = step_rem;
                        cnt_d = cnt_sat;
                        if ((len_q != '0) && (cnt_inc == {1'b0, len_q})) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: ;
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    // Divisor resets to 1 so the datapath never sees a zero divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            div_q   <= {{(DIV_W-1){1'b0}}, 1'b1};
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign remainder = rem_q;
    assign divisible = (rem_q == '0);
    assign done      = done_q;
    assign err_div0  = err_q;

endmodule : serial_divisibility_by_n_fsm

// File: tb/tb_serial_divisibility_by_n_fsm.sv
// Self-checking bench for serial_divisibility_by_n_fsm. A behavioural model
// tracks the running value modulo the divisor with plain integer arithmetic.
module tb_serial_divisibility_by_n_fsm;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] divisor;
    logic [5:0] num_len;
    logic       bit_valid;
    logic       new_bit;
    logic       busy;
    logic [7:0] remainder;
    logic       divisible;
    logic       done;
    logic       err_div0;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit m_run;
    int m_rem;
    int m_div;
    int m_len;
    int m_cnt;
    bit exp_done;
    bit exp_err;

    serial_divisibility_by_n_fsm #(
        .DIV_W (8),
        .LEN_W (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .divisor   (divisor),
        .num_len   (num_len),
        .bit_valid (bit_valid),
        .new_bit   (new_bit),
        .busy      (busy),
        .remainder (remainder),
        .divisible (divisible),
        .done      (done),
        .err_div0  (err_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_rem = 0; m_div = 1; m_len = 0; m_cnt = 0;
        exp_done = 0; exp_err = 0;
    endtask

    // Drives one cycle of inputs, advances the model, and leaves the bench
    // 1 time unit after the clock edge so outputs can be sampled.
    task automatic tick(input bit st, input int dv, input int ln, input bit bv, input bit b);
        start = st; divisor = 8'(dv); num_len = 6'(ln); bit_valid = bv; new_bit = b;
        @(posedge clk);
        #1;
        start = 0; bit_valid = 0;
        exp_done = 0; exp_err = 0;
        if (st) begin
            m_rem = 0;
            if (dv != 0) begin
                m_run = 1; m_cnt = 0; m_div = dv; m_len = ln;
            end else begin
                m_run = 0; exp_err = 1;
            end
        end else if (m_run && bv) begin
            m_rem = (m_rem * 2 + int'(b)) % m_div;
            m_cnt++;
            if (m_len != 0 && m_cnt == m_len) begin
                m_run = 0; exp_done = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; divisor = 0; num_len = 0; bit_valid = 0; new_bit = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (remainder !== 8'd0 || divisible !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err_div0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: rem=%0d div=%b busy=%b done=%b err=%b, want 0 1 0 0 0",
                     remainder, divisible, busy, done, err_div0);
        end
        rst_n = 1;
        #1;
    endtask

    task automatic test_bounded_frame();
        int exp_r[4] = '{1, 2, 0, 0};
        int bits[4]  = '{1, 0, 1, 0};
        tick(1, 5, 4, 0, 0);
        checks++;
        if (busy !== 1'b1 || remainder !== 8'd0) begin
            errors++;
            $display("[TB] FAIL bounded_start: busy=%b rem=%0d, want 1 0", busy, remainder);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 1, bits[i][0]);
            checks++;
            if (remainder !== 8'(exp_r[i]) || divisible !== (exp_r[i] == 0)) begin
                errors++;
                $display("[TB] FAIL bounded_rem[%0d]: rem=%0d div=%b, want %0d", i, remainder, divisible, exp_r[i]);
            end
            checks++;
            if (done !== (i == 3) || busy !== (i != 3)) begin
                errors++;
                $display("[TB] FAIL bounded_done[%0d]: done=%b busy=%b, want %b %b", i, done, busy, i == 3, i != 3);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 1, 1);
            checks++;
            if (remainder !== 8'd0 || divisible !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL done_hold[%0d]: rem=%0d div=%b done=%b busy=%b, want 0 1 0 0",
                         i, remainder, divisible, done, busy);
            end
        end
    endtask

    task automatic test_unbounded();
        int exp_r[5] = '{1, 3, 0, 1, 2};
        int bits[5]  = '{1, 1, 1, 1, 0};
        tick(1, 7, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 1, bits[i][0]);
            checks++;
            if (remainder !== 8'(exp_r[i]) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL unbounded[%0d]: rem=%0d busy=%b done=%b, want %0d 1 0",
                         i, remainder, busy, done, exp_r[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 1);
            checks++;
            if (remainder !== 8'd2 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL unbounded_hold[%0d]: rem=%0d busy=%b, want 2 1", i, remainder, busy);
            end
        end
    endtask

    task automatic test_max_divisor();
        int patterns[2] = '{255, 254};
        int finals[2]   = '{0, 254};
        for (int p = 0; p < 2; p++) begin
            tick(1, 255, 8, 0, 0);
            for (int i = 7; i >= 0; i--) begin
                tick(0, 0, 0, 1, patterns[p][i]);
                checks++;
                if (remainder !== 8'(m_rem)) begin
                    errors++;
                    $display("[TB] FAIL maxdiv_step: rem=%0d, want %0d", remainder, m_rem);
                end
            end
            checks++;
            if (remainder !== 8'(finals[p]) || divisible !== (finals[p] == 0) || done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL maxdiv_final[%0d]: rem=%0d div=%b done=%b, want %0d",
                         p, remainder, divisible, done, finals[p]);
            end
        end
    endtask

    task automatic test_div_zero();
        tick(1, 0, 3, 0, 0);
        checks++;
        if (err_div0 !== 1'b1 || busy !== 1'b0 || remainder !== 8'd0) begin
            errors++;
            $display("[TB] FAIL div0_pulse: err=%b busy=%b rem=%0d, want 1 0 0", err_div0, busy, remainder);
        end
        tick(0, 0, 0, 1, 1);
        checks++;
        if (err_div0 !== 1'b0 || busy !== 1'b0 || remainder !== 8'd0) begin
            errors++;
            $display("[TB] FAIL div0_after: err=%b busy=%b rem=%0d, want 0 0 0", err_div0, busy, remainder);
        end
        tick(0, 0, 0, 1, 1);
        checks++;
        if (remainder !== 8'd0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL div0_bits: rem=%0d done=%b, want 0 0", remainder, done);
        end
    endtask

    task automatic test_back_to_back();
        tick(1, 3, 4, 0, 0);
        tick(0, 0, 0, 1, 1);
        tick(0, 0, 0, 1, 1);
        checks++;
        if (remainder !== 8'd0) begin
            errors++;
            $display("[TB] FAIL b2b_first: rem=%0d, want 0", remainder);
        end
        tick(1, 5, 4, 1, 1);
        checks++;
        if (remainder !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_collide: rem=%0d busy=%b, want 0 1", remainder, busy);
        end
        tick(0, 0, 0, 1, 1);
        checks++;
        if (remainder !== 8'd1) begin
            errors++;
            $display("[TB] FAIL b2b_bit1: rem=%0d, want 1", remainder);
        end
        tick(0, 0, 0, 1, 1);
        checks++;
        if (remainder !== 8'd3 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_bit2: rem=%0d busy=%b, want 3 1", remainder, busy);
        end
    endtask

    task automatic test_async_reset();
        tick(1, 7, 10, 0, 0);
        tick(0, 0, 0, 1, 1);
        tick(0, 0, 0, 1, 1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (remainder !== 8'd0 || divisible !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err_div0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: rem=%0d div=%b busy=%b done=%b err=%b, want 0 1 0 0 0",
                     remainder, divisible, busy, done, err_div0);
        end
        #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1, 1);
            checks++;
            if (remainder !== 8'd0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL post_reset[%0d]: rem=%0d busy=%b, want 0 0", i, remainder, busy);
            end
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 100; f++) begin
            int dv;
            int ln;
            int sent;
            int guard;
            dv = (f % 10 == 0) ? 1 : int'($urandom_range(1, 255));
            ln = int'($urandom_range(1, 63));
            tick(1, dv, ln, 0, 0);
            sent = 0;
            guard = 0;
            while (sent < ln && guard < 400) begin
                bit bv;
                bv = ($urandom_range(0, 3) != 0);
                tick(0, 0, 0, bv, 1'($urandom));
                if (bv) sent++;
                guard++;
                checks++;
                if (remainder !== 8'(m_rem) || divisible !== (m_rem == 0) || busy !== m_run || done !== exp_done) begin
                    errors++;
                    $display("[TB] FAIL random[%0d]: rem=%0d div=%b busy=%b done=%b, want %0d %b %b %b",
                             f, remainder, divisible, busy, done, m_rem, m_rem == 0, m_run, exp_done);
                end
            end
            checks++;
            if (sent != ln) begin
                errors++;
                $display("[TB] FAIL random_guard[%0d]: sent=%0d, want %0d", f, sent, ln);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounded_frame();
        test_unbounded();
        test_max_divisor();
        test_div_zero();
        test_back_to_back();
        test_async_reset();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_divisibility_by_n_fsm
